// File: rtl/mem_port_arbiter_if.sv
// Bus bundle tying the fetch unit, the load/store unit and the shared RAM to mem_port_arbiter.
// The arbiter takes the slave modport; the surrounding core/RAM side takes master.
interface mem_port_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          ls_req;
  logic          ls_we;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic          ls_gnt;
  logic          ls_rvalid;
  logic [DW-1:0] ls_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing the core's RAM port between instruction fetch and load/store.
// Load/store has priority; a starvation counter forces a fetch grant after MAX_WAIT straight losses.
module mem_port_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MEM_LAT  = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_port_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, GRANT, WAIT, RESP} state_t;

  localparam logic [2:0] WAIT_INIT = 3'(MEM_LAT - 1);
  localparam logic [3:0] STARV_MAX = 4'(MAX_WAIT);

  state_t        r_state;
  state_t        w_nextState;
  logic          r_ownerLs;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [2:0]    r_waitCnt;
  logic [3:0]    r_starvCnt;
  logic          w_lsWin;
  logic          w_ifWin;

  assign w_lsWin = bus.ls_req && !(bus.if_req && (r_starvCnt >= STARV_MAX));
  assign w_ifWin = bus.if_req && !w_lsWin;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Request latch, WAIT down-counter and starvation counter; only IDLE looks at the request inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ownerLs  <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_waitCnt  <= 3'd0;
      r_starvCnt <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.if_req && w_lsWin) begin
            if (r_starvCnt < STARV_MAX) begin
              r_starvCnt <= r_starvCnt + 4'd1;
            end
          end else begin
            r_starvCnt <= 4'd0;
          end
          if (w_ifWin || w_lsWin) begin
            r_ownerLs <= w_lsWin;
            r_we      <= w_lsWin && bus.ls_we;
            r_addr    <= w_lsWin ? bus.ls_addr : bus.if_addr;
            r_wdata   <= w_lsWin ? bus.ls_wdata : '0;
          end
        end
        GRANT:   r_waitCnt <= WAIT_INIT;
        WAIT:    r_waitCnt <= r_waitCnt - 3'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_nextState   = r_state;
    bus.if_gnt    = 1'b0;
    bus.ls_gnt    = 1'b0;
    bus.if_rvalid = 1'b0;
    bus.ls_rvalid = 1'b0;
    bus.if_rdata  = '0;
    bus.ls_rdata  = '0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.busy      = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (w_ifWin || w_lsWin) begin
          w_nextState = GRANT;
        end
      end
      GRANT: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = r_we;
        bus.mem_addr  = r_addr;
        bus.mem_wdata = r_wdata;
        bus.if_gnt    = !r_ownerLs;
        bus.ls_gnt    = r_ownerLs;
        if (r_we) begin
          w_nextState = IDLE;
        end else if (MEM_LAT == 1) begin
          w_nextState = RESP;
        end else begin
          w_nextState = WAIT;
        end
      end
      WAIT: begin
        if (r_waitCnt <= 3'd1) begin
          w_nextState = RESP;
        end
      end
      RESP: begin
        bus.if_rvalid = !r_ownerLs;
        bus.ls_rvalid = r_ownerLs;
        if (r_ownerLs) begin
          bus.ls_rdata = bus.mem_rdata;
        end else begin
          bus.if_rdata = bus.mem_rdata;
        end
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a transaction-age reference model checked every cycle,
// directed scenarios with hand-computed expectations, then randomized requesters and resets.
module tb_mem_port_arbiter;

  localparam int AW       = 8;
  localparam int DW       = 8;
  localparam int MEM_LAT  = 3;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks;
  int errors;

  function automatic logic [7:0] initVal(input logic [7:0] a);
    case (a)
      8'h10:   return 8'hA5;
      8'h20:   return 8'h3C;
      default: return a ^ 8'h96;
    endcase
  endfunction

  // RAM stand-in: writes on the strobe edge, read data shows up MEM_LAT cycles after mem_en, junk otherwise
  logic [7:0] ram [256];
  logic [7:0] pipeData [MEM_LAT];
  logic       pipeValid [MEM_LAT];
  logic [7:0] junk;
  bit         ramInit = 1'b0;

  always @(posedge clk) begin
    junk <= 8'($urandom);
    if (!ramInit) begin
      for (int i = 0; i < 256; i++) ram[i] <= initVal(8'(i));
      for (int i = 0; i < MEM_LAT; i++) begin
        pipeValid[i] <= 1'b0;
        pipeData[i]  <= 8'h00;
      end
      ramInit <= 1'b1;
    end else begin
      if (bus.mem_en && bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      pipeValid[0] <= bus.mem_en && !bus.mem_we;
      pipeData[0]  <= ram[bus.mem_addr];
      for (int i = 1; i < MEM_LAT; i++) begin
        pipeValid[i] <= pipeValid[i-1];
        pipeData[i]  <= pipeData[i-1];
      end
    end
  end

  assign bus.mem_rdata = pipeValid[MEM_LAT-1] ? pipeData[MEM_LAT-1] : junk;

  // Reference model: age counts cycles since the winning IDLE sample (0 = idle)
  int         age;
  int         starv;
  bit         mLs;
  bit         mRd;
  logic [7:0] mAddr;
  logic [7:0] mWdata;
  logic [7:0] mmem [256];

  task automatic chkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkByte(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkInt(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    bit         g;
    bit         r;
    logic [7:0] d;
    g = (age == 1);
    r = mRd && (age == MEM_LAT + 1);
    d = r ? mmem[mAddr] : 8'h00;
    chkBit ("busy",      bus.busy,      age != 0);
    chkBit ("mem_en",    bus.mem_en,    g);
    chkBit ("mem_we",    bus.mem_we,    g && !mRd);
    chkByte("mem_addr",  bus.mem_addr,  g ? mAddr : 8'h00);
    chkByte("mem_wdata", bus.mem_wdata, g ? mWdata : 8'h00);
    chkBit ("if_gnt",    bus.if_gnt,    g && !mLs);
    chkBit ("ls_gnt",    bus.ls_gnt,    g && mLs);
    chkBit ("if_rvalid", bus.if_rvalid, r && !mLs);
    chkBit ("ls_rvalid", bus.ls_rvalid, r && mLs);
    chkByte("if_rdata",  bus.if_rdata,  (r && !mLs) ? d : 8'h00);
    chkByte("ls_rdata",  bus.ls_rdata,  (r && mLs) ? d : 8'h00);
  endtask

  task automatic modelUpdate();
    bit lsWin;
    bit ifWin;
    if (age == 1 && !mRd) mmem[mAddr] = mWdata;
    if (reset) begin
      age   = 0;
      starv = 0;
      return;
    end
    if (age == 0) begin
      lsWin = bus.ls_req && !(bus.if_req && starv >= MAX_WAIT);
      ifWin = bus.if_req && !lsWin;
      if (bus.if_req && lsWin) starv = (starv < MAX_WAIT) ? starv + 1 : starv;
      else starv = 0;
      if (lsWin || ifWin) begin
        age    = 1;
        mLs    = lsWin;
        mRd    = ifWin || !bus.ls_we;
        mAddr  = lsWin ? bus.ls_addr : bus.if_addr;
        mWdata = lsWin ? bus.ls_wdata : 8'h00;
      end
    end else begin
      age++;
      if (age == (mRd ? MEM_LAT + 2 : 2)) age = 0;
    end
  endtask

  task automatic applyStimulus(input bit ir, input logic [7:0] ia, input bit lr, input bit lw,
                               input logic [7:0] la, input logic [7:0] ld, input bit rst);
    reset        = rst;
    bus.if_req   = ir;
    bus.if_addr  = ia;
    bus.ls_req   = lr;
    bus.ls_we    = lw;
    bus.ls_addr  = la;
    bus.ls_wdata = ld;
    #1;
    checkOutput();
  endtask

  task automatic endCycle();
    modelUpdate();
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      endCycle();
    end
  endtask

  bit         ifPend;
  bit         lsPend;
  bit         lsW;
  bit         rstR;
  logic [7:0] ifA;
  logic [7:0] lsA;
  logic [7:0] lsD;
  int         cnt;
  int         ng;
  int         nls;
  bit         gSeq [6];

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) mmem[i] = initVal(8'(i));
    age = 0; starv = 0; mLs = 1'b0; mRd = 1'b0; mAddr = 8'h00; mWdata = 8'h00;
    reset = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = 8'h00; bus.ls_req = 1'b0; bus.ls_we = 1'b0;
    bus.ls_addr = 8'h00; bus.ls_wdata = 8'h00;
    @(negedge clk);

    // Reset state, then reset colliding with requests
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    chkBit("rst_busy", bus.busy, 1'b0);
    chkBit("rst_mem_en", bus.mem_en, 1'b0);
    endCycle();
    applyStimulus(1'b1, 8'h33, 1'b1, 1'b1, 8'h34, 8'h35, 1'b1);
    endCycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    chkBit("rst_req_dropped", bus.busy, 1'b0);
    endCycle();

    // Single fetch
    applyStimulus(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    endCycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    chkBit("f_gnt", bus.if_gnt, 1'b1);
    chkBit("f_en", bus.mem_en, 1'b1);
    chkBit("f_we", bus.mem_we, 1'b0);
    chkByte("f_addr", bus.mem_addr, 8'h10);
    endCycle();
    idleCycles(2);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    chkBit("f_rvalid", bus.if_rvalid, 1'b1);
    chkByte("f_rdata", bus.if_rdata, 8'hA5);
    endCycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    chkBit("f_busy_after", bus.busy, 1'b0);
    endCycle();

    // Store, then a load of the same address
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 8'h30, 8'h5C, 1'b0);
    endCycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    chkBit("s_gnt", bus.ls_gnt, 1'b1);
    chkBit("s_we", bus.mem_we, 1'b1);
    chkByte("s_addr", bus.mem_addr, 8'h30);
    chkByte("s_wdata", bus.mem_wdata, 8'h5C);
    endCycle();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h30, 8'h00, 1'b0);
    chkBit("s_busy_after", bus.busy, 1'b0);
    chkBit("s_no_rvalid", bus.ls_rvalid, 1'b0);
    endCycle();
    idleCycles(3);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    chkBit("sl_rvalid", bus.ls_rvalid, 1'b1);
    chkByte("sl_rdata", bus.ls_rdata, 8'h5C);
    endCycle();
    idleCycles(1);

    // Simultaneous requests: LS first, IF on the next arbitration
    applyStimulus(1'b1, 8'h11, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0);
    endCycle();
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    chkBit("sim_ls_gnt", bus.ls_gnt, 1'b1);
    chkBit("sim_if_gnt0", bus.if_gnt, 1'b0);
    chkByte("sim_addr_ls", bus.mem_addr, 8'h20);
    endCycle();
    repeat (2) begin
      applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      endCycle();
    end
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    chkByte("sim_ls_rdata", bus.ls_rdata, 8'h3C);
    endCycle();
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    endCycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    chkBit("sim_if_gnt", bus.if_gnt, 1'b1);
    chkByte("sim_addr_if", bus.mem_addr, 8'h11);
    endCycle();
    idleCycles(5);

    // Withdrawn LS request during an IF grant
    applyStimulus(1'b1, 8'h12, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    endCycle();
    cnt = 0;
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h21, 8'h00, 1'b0);
    if (bus.ls_gnt) cnt++;
    endCycle();
    repeat (4) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      if (bus.ls_gnt) cnt++;
      endCycle();
    end
    chkInt("wd_no_ls_gnt", cnt, 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    chkBit("wd_busy", bus.busy, 1'b0);
    endCycle();

    // Starvation guard: four LS stores, forced IF, then LS again
    ng = 0;
    for (int c = 0; c < 80 && ng < 6; c++) begin
      applyStimulus(1'b1, 8'h50, 1'b1, 1'b1, 8'(8'h60 + ng), 8'(8'h70 + ng), 1'b0);
      if (bus.if_gnt || bus.ls_gnt) begin
        gSeq[ng] = bus.ls_gnt;
        ng++;
      end
      endCycle();
    end
    chkInt("starv_grants", ng, 6);
    chkBit("starv_g0", gSeq[0], 1'b1);
    chkBit("starv_g1", gSeq[1], 1'b1);
    chkBit("starv_g2", gSeq[2], 1'b1);
    chkBit("starv_g3", gSeq[3], 1'b1);
    chkBit("starv_g4", gSeq[4], 1'b0);
    chkBit("starv_g5", gSeq[5], 1'b1);
    idleCycles(6);

    // Reset during WAIT of a fetch
    applyStimulus(1'b1, 8'h40, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    endCycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    chkBit("rw_gnt", bus.if_gnt, 1'b1);
    endCycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    endCycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    chkBit("rw_busy", bus.busy, 1'b0);
    chkBit("rw_rvalid", bus.if_rvalid, 1'b0);
    endCycle();
    cnt = 0;
    repeat (6) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      if (bus.if_rvalid) cnt++;
      endCycle();
    end
    chkInt("rw_no_rvalid", cnt, 0);
    applyStimulus(1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    endCycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    chkBit("rw_fresh_gnt", bus.if_gnt, 1'b1);
    chkByte("rw_fresh_addr", bus.mem_addr, 8'h41);
    endCycle();
    idleCycles(5);

    // Reset clears a saturated starvation count: LS must win the next contest
    nls = 0;
    for (int c = 0; c < 60 && nls < 4; c++) begin
      applyStimulus(1'b1, 8'h42, 1'b1, (nls < 3), 8'h62, 8'h11, 1'b0);
      if (bus.ls_gnt) nls++;
      endCycle();
    end
    chkInt("sr_ls_wins", nls, 4);
    applyStimulus(1'b1, 8'h42, 1'b1, 1'b0, 8'h62, 8'h11, 1'b1);
    endCycle();
    applyStimulus(1'b1, 8'h42, 1'b1, 1'b0, 8'h63, 8'h11, 1'b0);
    chkBit("sr_idle", bus.busy, 1'b0);
    endCycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    chkBit("sr_ls_gnt", bus.ls_gnt, 1'b1);
    chkBit("sr_if_gnt", bus.if_gnt, 1'b0);
    endCycle();
    idleCycles(6);

    // Randomized requesters with occasional withdrawal and reset
    ifPend = 1'b0; lsPend = 1'b0; lsW = 1'b0;
    ifA = 8'h00; lsA = 8'h00; lsD = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      rstR = ($urandom_range(0, 149) == 0);
      if (!ifPend && $urandom_range(0, 2) == 0) begin
        ifPend = 1'b1;
        ifA    = 8'($urandom_range(0, 15));
      end else if (ifPend && $urandom_range(0, 19) == 0) begin
        ifPend = 1'b0;
      end
      if (!lsPend && $urandom_range(0, 1) == 0) begin
        lsPend = 1'b1;
        lsW    = 1'($urandom_range(0, 1));
        lsA    = 8'($urandom_range(0, 15));
        lsD    = 8'($urandom);
      end else if (lsPend && $urandom_range(0, 19) == 0) begin
        lsPend = 1'b0;
      end
      applyStimulus(ifPend, ifA, lsPend, lsW, lsA, lsD, rstR);
      if (bus.if_gnt) ifPend = 1'b0;
      if (bus.ls_gnt) lsPend = 1'b0;
      endCycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-port program/data RAM of the microprocessor between the instruction-fetch unit (IF) and the load/store unit (LS). Only one transaction is outstanding at a time. LS has fixed priority, with a starvation guard that forces an IF grant after MAX_WAIT consecutive losses. The block sits between the core's fetch/LSU front ends and the synchronous RAM instance inside the microprocessor top level.

Parameters:
AW, 8, address width
DW, 8, data width
MEM_LAT, 1, RAM read latency in cycles from mem_en to valid mem_rdata; legal range 1..7
MAX_WAIT, 4, consecutive IF losses before IF is forced to win; legal range 1..15

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
if_req  input  1  fetch request; held with if_addr until if_gnt
if_addr  input  AW  fetch address
if_gnt  output  1  one-cycle grant pulse to IF
if_rvalid  output  1  one-cycle fetch data valid
if_rdata  output  DW  fetch data; 0 when if_rvalid=0
ls_req  input  1  load/store request; held with other ls_* until ls_gnt
ls_we  input  1  1=store, 0=load
ls_addr  input  AW  load/store address
ls_wdata  input  DW  store data
ls_gnt  output  1  one-cycle grant pulse to LS
ls_rvalid  output  1  one-cycle load data valid (loads only)
ls_rdata  output  DW  load data; 0 when ls_rvalid=0
mem_en  output  1  RAM access strobe
mem_we  output  1  RAM write enable
mem_addr  output  AW  RAM address
mem_wdata  output  DW  RAM write data
mem_rdata  input  DW  RAM read data, valid MEM_LAT cycles after mem_en
busy  output  1  1 when state is not IDLE

Behaviour:
- Reset values: all outputs 0, state IDLE, starvation counter 0, owner register 0.
- FSM states:
  - IDLE: arbitrate using req inputs sampled at the clock edge.
    - Any request -> GRANT.
    - No request -> stay in IDLE.
  - GRANT: exactly one cycle.
    - mem_en=1.
    - Winner's gnt=1.
    - mem_we/mem_addr/mem_wdata driven from the winner's latched request. IF access: mem_we=0, mem_wdata=0.
    - Next state: store -> IDLE; read and MEM_LAT=1 -> RESP; read and MEM_LAT>1 -> WAIT.
  - WAIT: stays for MEM_LAT-1 cycles (down-counter), then -> RESP.
  - RESP: exactly one cycle.
    - Owner's rvalid=1; owner's rdata=mem_rdata (combinational pass-through).
    - Next state: IDLE.
- Output gating:
  - When mem_en=0: mem_we, mem_addr and mem_wdata are 0.
  - The gnt and rvalid of the non-owner are always 0.
- Latency, measured from the IDLE cycle in which req is sampled:
  - gnt is asserted one cycle later.
  - Read data arrives MEM_LAT+1 cycles later.
  - Store occupancy is 2 cycles (IDLE + GRANT). Read occupancy is MEM_LAT+2 cycles.
  - No new arbitration happens in GRANT, WAIT or RESP. The earliest next grant is the cycle after returning to IDLE.
- Arbitration in IDLE:
  - Only if_req=1 -> IF wins. Only ls_req=1 -> LS wins.
  - Both requesting, starv_cnt < MAX_WAIT -> LS wins.
  - Both requesting, starv_cnt == MAX_WAIT -> IF wins.
- Starvation counter starv_cnt (4 bits), updated only on IDLE decisions with a request:
  - Incremented, saturating at MAX_WAIT, when LS wins while if_req=1.
  - Cleared when IF wins.
  - Cleared in any IDLE cycle with if_req=0.
- Requester protocol: a requester deasserting req before gnt is legal. The request is simply not seen. The request is latched only at the IDLE->GRANT edge, so input changes after that edge have no effect.
- Reset mid-operation (any state): next cycle is IDLE with all outputs 0. Pending rvalid is dropped, the WAIT counter and starv_cnt are cleared, and no gnt or rvalid is generated for the aborted access.
- Simultaneous reset and req: reset dominates and the request is not latched.

Test Plan:
- Single fetch, MEM_LAT=1: if_req=1, if_addr=8'h10 in cycle 0 -> cycle 1: mem_en=1, mem_addr=8'h10, mem_we=0, if_gnt=1. Cycle 2: RAM returns 8'hA5 -> if_rvalid=1, if_rdata=8'hA5. Cycle 3: busy=0.
- Simultaneous requests: if_req=1 and ls_req=1 (ls_we=0, ls_addr=8'h20) -> LS granted first with mem_addr=8'h20. IF granted on the next arbitration (if_addr=8'h11) because ls_req was dropped after ls_gnt.
- Starvation, MAX_WAIT=4: ls_req held high continuously (stores) with if_req high -> exactly 4 consecutive ls_gnt pulses, 5th grant is if_gnt, 6th grant returns to LS.
- Store: ls_req=1, ls_we=1, ls_addr=8'h30, ls_wdata=8'h5C -> one cycle later mem_en=1, mem_we=1, mem_addr=8'h30, mem_wdata=8'h5C, ls_gnt=1. ls_rvalid never asserts. busy=0 on the following cycle.
- Reset in WAIT, MEM_LAT=3: fetch granted, reset asserted in first WAIT cycle -> next cycle all outputs 0, if_rvalid never asserts. A fresh if_req after reset is granted normally with starv_cnt=0 behaviour.
- Withdrawn request: ls_req pulsed high during GRANT of an IF access, low by IDLE -> no ls_gnt, no mem_en for LS, busy returns to 0.
